// File: rtl/multiport_ram_pkg.sv
// +----------------------------------------------------------------------------+
// | multiport_ram_pkg : shared types and width helpers for the RAM write-back  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package multiport_ram_pkg;

    localparam int C_MEM_DEPTH  = 16;
    localparam int C_MEM_WIDTH  = 32;
    localparam int C_FIFO_DEPTH = 8;

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_width(input int fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction

    localparam int C_INDEX_WIDTH = index_width(C_MEM_DEPTH);
    localparam int C_OCC_WIDTH   = occ_width(C_FIFO_DEPTH);

    typedef struct packed {
        logic [C_INDEX_WIDTH-1:0] addr;
        logic [C_MEM_WIDTH-1:0]   data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// +----------------------------------------------------------------------------+
// | wb_fifo : 2-push / 2-pop register circular buffer exposing head, head+1    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  logic [WIDTH-1:0]       din0,
    input  logic                   push1,
    input  logic [WIDTH-1:0]       din1,
    input  logic [1:0]             pop_cnt,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       head_next,
    output logic [$clog2(DEPTH):0] count
);
    import multiport_ram_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = occ_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_push_cnt;
    logic [PTR_W-1:0] w_wr_ptr1;

    assign w_push_cnt = {1'b0, push0} + {1'b0, push1};
    // Lane 1 lands right behind lane 0 when both push, else in lane 0's slot.
    assign w_wr_ptr1  = r_wr_ptr + PTR_W'(push0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(pop_cnt);
            r_count  <= r_count + CNT_W'(w_push_cnt) - CNT_W'(pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (push0) begin
            r_mem[r_wr_ptr] <= din0;
        end
        if (push1) begin
            r_mem[w_wr_ptr1] <= din1;
        end
    end

    assign head      = r_mem[r_rd_ptr];
    assign head_next = r_mem[r_rd_ptr + PTR_W'(1)];
    assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | regfile_wb_arbiter : two-lane write-back queue draining onto RAM ports A/B |
// | Optional stall/serialisation counters: define REGFILE_WB_ARB_STATS_EN      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter #(
    parameter int P_MEM_DEPTH  = 16,
    parameter int P_MEM_WIDTH  = 32,
    parameter int P_FIFO_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in0_valid_i,
    output logic                            in0_ready_o,
    input  logic [$clog2(P_MEM_DEPTH)-1:0]  in0_addr_i,
    input  logic [P_MEM_WIDTH-1:0]          in0_data_i,
    input  logic                            in1_valid_i,
    output logic                            in1_ready_o,
    input  logic [$clog2(P_MEM_DEPTH)-1:0]  in1_addr_i,
    input  logic [P_MEM_WIDTH-1:0]          in1_data_i,
    output logic [$clog2(P_MEM_DEPTH)-1:0]  wra_addr_o,
    output logic [P_MEM_WIDTH-1:0]          wra_data_o,
    output logic                            wra_valid_o,
    output logic [$clog2(P_MEM_DEPTH)-1:0]  wrb_addr_o,
    output logic [P_MEM_WIDTH-1:0]          wrb_data_o,
    output logic                            wrb_valid_o,
`ifdef REGFILE_WB_ARB_STATS_EN
    output logic [31:0]                     stall_cnt_o,
    output logic [31:0]                     serial_cnt_o,
`endif
    output logic [$clog2(P_FIFO_DEPTH):0]   occupancy_o
);
    import multiport_ram_pkg::*;

    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);
    localparam int LP_ENTRY_WIDTH = LP_INDEX_WIDTH + P_MEM_WIDTH;
    localparam int LP_OCC_WIDTH   = occ_width(P_FIFO_DEPTH);
    localparam logic [LP_OCC_WIDTH-1:0] C_DEPTH = LP_OCC_WIDTH'(P_FIFO_DEPTH);

    logic                      w_push0;
    logic                      w_push1;
    logic [LP_ENTRY_WIDTH-1:0] w_head;
    logic [LP_ENTRY_WIDTH-1:0] w_head_next;
    logic [LP_INDEX_WIDTH-1:0] w_head_addr;
    logic [LP_INDEX_WIDTH-1:0] w_next_addr;
    logic                      w_same_addr;
    logic                      w_two;
    logic                      w_va;
    logic                      w_vb;
    logic [1:0]                w_pop_cnt;

    // Ready depends on registered occupancy only, so there is no valid->ready path.
    assign in0_ready_o = (occupancy_o < C_DEPTH);
    assign in1_ready_o = (occupancy_o < (C_DEPTH - LP_OCC_WIDTH'(1)));

    assign w_push0 = in0_valid_i & in0_ready_o;
    assign w_push1 = in1_valid_i & in1_ready_o;

    wb_fifo #(
        .DEPTH (P_FIFO_DEPTH),
        .WIDTH (LP_ENTRY_WIDTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push0     (w_push0),
        .din0      ({in0_addr_i, in0_data_i}),
        .push1     (w_push1),
        .din1      ({in1_addr_i, in1_data_i}),
        .pop_cnt   (w_pop_cnt),
        .head      (w_head),
        .head_next (w_head_next),
        .count     (occupancy_o)
    );

    assign w_head_addr = w_head[P_MEM_WIDTH +: LP_INDEX_WIDTH];
    assign w_next_addr = w_head_next[P_MEM_WIDTH +: LP_INDEX_WIDTH];
    assign w_same_addr = (w_head_addr == w_next_addr);
    assign w_two       = (occupancy_o > LP_OCC_WIDTH'(1));

    // Same-address pairs issue one per cycle so the younger write lands last.
    assign w_va      = (occupancy_o != '0);
    assign w_vb      = w_two & ~w_same_addr;
    assign w_pop_cnt = {1'b0, w_va} + {1'b0, w_vb};

    assign wra_valid_o = w_va;
    assign wra_addr_o  = w_va ? w_head_addr : '0;
    assign wra_data_o  = w_va ? w_head[P_MEM_WIDTH-1:0] : '0;
    assign wrb_valid_o = w_vb;
    assign wrb_addr_o  = w_vb ? w_next_addr : '0;
    assign wrb_data_o  = w_vb ? w_head_next[P_MEM_WIDTH-1:0] : '0;

`ifdef REGFILE_WB_ARB_STATS_EN
    logic        w_stall;
    logic        w_serial;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_serial_cnt;

    assign w_stall  = (in0_valid_i & ~in0_ready_o) | (in1_valid_i & ~in1_ready_o);
    assign w_serial = w_two & w_same_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_serial_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_serial && (r_serial_cnt != '1)) begin
                r_serial_cnt <= r_serial_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign serial_cnt_o = r_serial_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter : vector table plus queue scoreboard for the arbiter |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_wb_arbiter;
    import multiport_ram_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in0_valid, in0_ready, in1_valid, in1_ready;
    logic [AW-1:0] in0_addr, in1_addr, wra_addr, wrb_addr;
    logic [DW-1:0] in0_data, in1_data, wra_data, wrb_data;
    logic          wra_valid, wrb_valid;
    logic [3:0]    occupancy;
`ifdef REGFILE_WB_ARB_STATS_EN
    logic [31:0]   stall_cnt, serial_cnt;
`endif

    int total = 0;
    int bad   = 0;

    wb_entry_t     mq[$];
    logic [DW-1:0] ram_dut [16];
    logic [DW-1:0] ram_ref [16];

    typedef struct {
        logic v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic ea; logic [AW-1:0] eaa; logic [DW-1:0] ead;
        logic eb; logic [AW-1:0] eba; logic [DW-1:0] ebd;
        logic [3:0] eocc;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .P_MEM_DEPTH  (16),
        .P_MEM_WIDTH  (DW),
        .P_FIFO_DEPTH (FD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in0_valid_i  (in0_valid),
        .in0_ready_o  (in0_ready),
        .in0_addr_i   (in0_addr),
        .in0_data_i   (in0_data),
        .in1_valid_i  (in1_valid),
        .in1_ready_o  (in1_ready),
        .in1_addr_i   (in1_addr),
        .in1_data_i   (in1_data),
        .wra_addr_o   (wra_addr),
        .wra_data_o   (wra_data),
        .wra_valid_o  (wra_valid),
        .wrb_addr_o   (wrb_addr),
        .wrb_data_o   (wrb_data),
        .wrb_valid_o  (wrb_valid),
`ifdef REGFILE_WB_ARB_STATS_EN
        .stall_cnt_o  (stall_cnt),
        .serial_cnt_o (serial_cnt),
`endif
        .occupancy_o  (occupancy)
    );

    // RAM image built only from what the DUT actually writes.
    always @(posedge clk) begin
        if (!rst) begin
            if (wra_valid) ram_dut[wra_addr] <= wra_data;
            if (wrb_valid) ram_dut[wrb_addr] <= wrb_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock of scoreboard-checked traffic; entered and left at posedge+1.
    task automatic cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output logic acc0, output logic acc1);
        int        sz;
        logic      eb;
        wb_entry_t e;
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        @(negedge clk);
        sz = mq.size();
        chk("occ", 64'(occupancy), 64'(sz));
        chk("rdy0", 64'(in0_ready), 64'(sz < FD));
        chk("rdy1", 64'(in1_ready), 64'(sz <= FD - 2));
        chk("va", 64'(wra_valid), 64'(sz >= 1));
        eb = (sz >= 2) && (mq[0].addr != mq[1].addr);
        chk("vb", 64'(wrb_valid), 64'(eb));
        if (sz >= 1 && wra_valid) begin
            chk("a_addr", 64'(wra_addr), 64'(mq[0].addr));
            chk("a_data", 64'(wra_data), 64'(mq[0].data));
        end
        if (eb && wrb_valid) begin
            chk("b_addr", 64'(wrb_addr), 64'(mq[1].addr));
            chk("b_data", 64'(wrb_data), 64'(mq[1].data));
        end
        if (sz >= 1) begin
            ram_ref[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
        end
        if (eb) begin
            ram_ref[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
        end
        acc0 = v0 && (sz < FD);
        acc1 = v1 && (sz <= FD - 2);
        if (acc0) begin e.addr = a0; e.data = d0; mq.push_back(e); end
        if (acc1) begin e.addr = a1; e.data = d1; mq.push_back(e); end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic x0, x1;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, x0, x1);
    endtask

    initial begin
        logic          k0, k1;
        logic          p0v, p1v;
        logic [AW-1:0] p0a, p1a;
        logic [DW-1:0] p0d, p1d;
`ifdef REGFILE_WB_ARB_STATS_EN
        logic [31:0]   s0;
`endif
        in0_valid = 0; in0_addr = '0; in0_data = '0;
        in1_valid = 0; in1_addr = '0; in1_data = '0;
        for (int i = 0; i < 16; i++) begin ram_dut[i] = '0; ram_ref[i] = '0; end

        vecs[0] = '{1'b1, 4'd3, 32'hA5A5_0003, 1'b0, 4'd0, 32'h0,
                    1'b1, 4'd3, 32'hA5A5_0003, 1'b0, 4'd0, 32'h0, 4'd1};
        vecs[1] = '{1'b1, 4'd2, 32'h11, 1'b1, 4'd9, 32'h22,
                    1'b1, 4'd2, 32'h11, 1'b1, 4'd9, 32'h22, 4'd2};
        vecs[2] = '{1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2,
                    1'b1, 4'd5, 32'h1, 1'b0, 4'd0, 32'h0, 4'd2};
        vecs[3] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h77,
                    1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0, 4'd1};
        vecs[4] = '{1'b1, 4'd0, 32'hDEAD_BEEF, 1'b1, 4'd15, 32'hCAFE_F00D,
                    1'b1, 4'd0, 32'hDEAD_BEEF, 1'b1, 4'd15, 32'hCAFE_F00D, 4'd2};
        vecs[5] = '{1'b0, 4'd1, 32'h5, 1'b0, 4'd2, 32'h6,
                    1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_va", 64'(wra_valid), 64'd0);
        chk("rst_vb", 64'(wrb_valid), 64'd0);
        chk("rst_aaddr", 64'(wra_addr), 64'd0);
        chk("rst_adata", 64'(wra_data), 64'd0);
        chk("rst_baddr", 64'(wrb_addr), 64'd0);
        chk("rst_bdata", 64'(wrb_data), 64'd0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("idle_rdy0", 64'(in0_ready), 64'd1);
        chk("idle_rdy1", 64'(in1_ready), 64'd1);
        chk("idle_occ", 64'(occupancy), 64'd0);
        @(posedge clk); #1;

        // Single-edge vectors from an empty queue
        for (int i = 0; i < 6; i++) begin
            in0_valid = vecs[i].v0; in0_addr = vecs[i].a0; in0_data = vecs[i].d0;
            in1_valid = vecs[i].v1; in1_addr = vecs[i].a1; in1_data = vecs[i].d1;
            @(posedge clk); #1;
            in0_valid = 0; in1_valid = 0;
            @(negedge clk);
            chk("vec_occ", 64'(occupancy), 64'(vecs[i].eocc));
            chk("vec_va", 64'(wra_valid), 64'(vecs[i].ea));
            chk("vec_vb", 64'(wrb_valid), 64'(vecs[i].eb));
            if (vecs[i].ea) begin
                chk("vec_aaddr", 64'(wra_addr), 64'(vecs[i].eaa));
                chk("vec_adata", 64'(wra_data), 64'(vecs[i].ead));
            end
            if (vecs[i].eb) begin
                chk("vec_baddr", 64'(wrb_addr), 64'(vecs[i].eba));
                chk("vec_bdata", 64'(wrb_data), 64'(vecs[i].ebd));
            end
            if (vecs[i].v0) ram_ref[vecs[i].a0] = vecs[i].d0;
            if (vecs[i].v1) ram_ref[vecs[i].a1] = vecs[i].d1;
            for (int k = 0; k < 4 && occupancy != 0; k++) @(negedge clk);
            chk("vec_drain", 64'(occupancy), 64'd0);
            @(posedge clk); #1;
        end

        // Same-address pair: serialised, younger write lands last
`ifdef REGFILE_WB_ARB_STATS_EN
        s0 = serial_cnt;
`endif
        cycle(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2, k0, k1);
        idle(3);
        chk("ram5", 64'(ram_dut[5]), 64'h2);
`ifdef REGFILE_WB_ARB_STATS_EN
        chk("serial_cnt", 64'(serial_cnt - s0), 64'd1);
`endif

        // Fill: constant address forces one pop per cycle against two pushes
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 4'hC, 32'h1000 + 2 * i, 1'b1, 4'hC, 32'h1001 + 2 * i, k0, k1);
        #2;
        chk("fill_occ7", 64'(occupancy), 64'd7);
        chk("fill_rdy0", 64'(in0_ready), 64'd1);
        chk("fill_rdy1", 64'(in1_ready), 64'd0);
        idle(9);

        // Reset with five entries queued
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 4'h6, 32'h600 + 2 * i, 1'b1, 4'h6, 32'h601 + 2 * i, k0, k1);
        in0_valid = 0; in1_valid = 0;
        #2;
        chk("pre_rst_occ", 64'(occupancy), 64'd5);
        rst = 1;
        #1;
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_va", 64'(wra_valid), 64'd0);
        chk("arst_vb", 64'(wrb_valid), 64'd0);
        mq.delete();
        @(posedge clk); #1; rst = 0;
        idle(3);

        // Random traffic with producers holding rejected data
        p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        k0 = 1; k1 = 1;
        for (int i = 0; i < 10000; i++) begin
            if (!p0v || k0) begin
                p0v = ($urandom_range(0, 3) != 0);
                p0a = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                p0d = $urandom;
            end
            if (!p1v || k1) begin
                p1v = ($urandom_range(0, 3) != 0);
                p1a = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                p1d = $urandom;
            end
            cycle(p0v, p0a, p0d, p1v, p1a, p1d, k0, k1);
        end
        idle(10);
        for (int i = 0; i < 16; i++) chk("ram_final", 64'(ram_dut[i]), 64'(ram_ref[i]));
`ifdef REGFILE_WB_ARB_STATS_EN
        chk("stall_seen", 64'(stall_cnt != 0), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
